// File: rtl/mem_stage_param.sv
// MEM pipeline stage: byte-addressed data memory with a fixed multi-cycle
// access latency, load extension, misalignment detection and a MEM/WB register.
module mem_stage_param #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int REG_W   = 3,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [REG_W-1:0]  in_alu_rd,
    input  logic [REG_W-1:0]  in_mem_rd,
    input  logic [DATA_W-1:0] in_alu_out,
    input  logic [ADDR_W-1:0] in_mem_addr,
    input  logic [1:0]        in_mem_op,
    input  logic [1:0]        in_mem_size,
    input  logic              in_mem_signed,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic              fwd_store_sel,
    input  logic [DATA_W-1:0] fwd_store_data,
    input  logic [3:0]        in_flags,
    output logic              stall,
    output logic              out_valid,
    output logic [REG_W-1:0]  out_alu_rd,
    output logic [REG_W-1:0]  out_mem_rd,
    output logic [DATA_W-1:0] out_alu_out,
    output logic [DATA_W-1:0] out_mem_out,
    output logic [3:0]        out_flags,
    output logic              out_misaligned
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LATENCY - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        mem_q [DEPTH];

    logic              is_ld, is_st, mis, acc, done;
    logic [AW-1:0]     idx [4];
    logic [31:0]       raw;
    logic [DATA_W-1:0] st_data, ld_data;
    logic [3:0]        mem_we;

    logic              out_valid_q, out_valid_d;
    logic [REG_W-1:0]  out_alu_rd_q, out_alu_rd_d;
    logic [REG_W-1:0]  out_mem_rd_q, out_mem_rd_d;
    logic [DATA_W-1:0] out_alu_out_q, out_alu_out_d;
    logic [DATA_W-1:0] out_mem_out_q, out_mem_out_d;
    logic [3:0]        out_flags_q, out_flags_d;
    logic              out_mis_q, out_mis_d;

    // Decode the access, gather the (wrapping) little-endian bytes and extend load data
    always_comb begin
        is_ld   = (in_mem_op == 2'b01);
        is_st   = (in_mem_op == 2'b10);
        mis     = (is_ld || is_st) &&
                  (((in_mem_size == 2'b01) && in_mem_addr[0]) ||
                   (in_mem_size[1] && (in_mem_addr[1:0] != 2'b00)));
        acc     = in_valid && (is_ld || is_st) && !mis;
        // An access finishes on the edge it is presented (LATENCY=1) or on the last BUSY cycle
        done    = acc && ((LATENCY == 1) || ((state_q == BUSY) && (cnt_q == LAST)));
        st_data = fwd_store_sel ? fwd_store_data : in_store_data;
        for (int k = 0; k < 4; k++) begin
            idx[k] = in_mem_addr[AW-1:0] + AW'(k);
        end
        raw = {mem_q[idx[3]], mem_q[idx[2]], mem_q[idx[1]], mem_q[idx[0]]};
        case (in_mem_size)
            2'b00:   ld_data = in_mem_signed ? DATA_W'($signed(raw[7:0]))  : DATA_W'(raw[7:0]);
            2'b01:   ld_data = in_mem_signed ? DATA_W'($signed(raw[15:0])) : DATA_W'(raw[15:0]);
            default: ld_data = in_mem_signed ? DATA_W'($signed(raw))       : DATA_W'(raw);
        endcase
        mem_we = 4'b0000;
        if (reset && done && is_st) begin
            case (in_mem_size)
                2'b00:   mem_we = 4'b0001;
                2'b01:   mem_we = 4'b0011;
                default: mem_we = 4'b1111;
            endcase
        end
    end

    // Latency FSM: IDLE launches an access, BUSY counts until the completing cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc && (LATENCY > 1)) begin
                    stall   = 1'b1;
                    state_d = BUSY;
                    cnt_d   = CNT_W'(1);
                end
            end
            BUSY: begin
                stall = (cnt_q != LAST);
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (!reset) stall = 1'b0;
    end

    // MEM/WB next value: bubble while stalled, otherwise capture the instruction
    always_comb begin
        out_valid_d   = out_valid_q;
        out_alu_rd_d  = out_alu_rd_q;
        out_mem_rd_d  = out_mem_rd_q;
        out_alu_out_d = out_alu_out_q;
        out_mem_out_d = out_mem_out_q;
        out_flags_d   = out_flags_q;
        out_mis_d     = out_mis_q;
        if (stall) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d   = in_valid;
            out_alu_rd_d  = in_alu_rd;
            out_mem_rd_d  = in_mem_rd;
            out_alu_out_d = in_alu_out;
            out_flags_d   = in_flags;
            out_mis_d     = in_valid && mis;
            out_mem_out_d = (acc && is_ld) ? ld_data : '0;
        end
    end

    // State, counter and MEM/WB registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            out_alu_rd_q  <= '0;
            out_mem_rd_q  <= '0;
            out_alu_out_q <= '0;
            out_mem_out_q <= '0;
            out_flags_q   <= '0;
            out_mis_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            out_valid_q   <= out_valid_d;
            out_alu_rd_q  <= out_alu_rd_d;
            out_mem_rd_q  <= out_mem_rd_d;
            out_alu_out_q <= out_alu_out_d;
            out_mem_out_q <= out_mem_out_d;
            out_flags_q   <= out_flags_d;
            out_mis_q     <= out_mis_d;
        end
    end

    // Data memory byte writes; contents survive reset
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (mem_we[k]) mem_q[idx[k]] <= st_data[8*k +: 8];
        end
    end

    assign out_valid      = out_valid_q;
    assign out_alu_rd     = out_alu_rd_q;
    assign out_mem_rd     = out_mem_rd_q;
    assign out_alu_out    = out_alu_out_q;
    assign out_mem_out    = out_mem_out_q;
    assign out_flags      = out_flags_q;
    assign out_misaligned = out_mis_q;
endmodule
